// File: rtl/twiddle_if.sv
// Coefficient-stream bundle between a twiddle sequencer and its consumer.
// The sequencer takes the slave side; the requester/consumer takes master.
interface twiddle_if #(
  parameter int NBITS = 16,
  parameter int N     = 8,
  parameter int LANES = 2
);
  localparam int W  = 2*NBITS;
  localparam int SW = $clog2(N);

  logic                 start;
  logic [SW-1:0]        shift;
  logic                 inverse;
  logic                 loop;
  logic [N*W-1:0]       coeff_table;
  logic                 out_ready;
  logic                 out_valid;
  logic [LANES*W-1:0]   coeff_out;
  logic                 busy;
  logic                 done;

  modport master (
    output start, shift, inverse, loop, coeff_table, out_ready,
    input  out_valid, coeff_out, busy, done
  );
  modport slave (
    input  start, shift, inverse, loop, coeff_table, out_ready,
    output out_valid, coeff_out, busy, done
  );
endinterface

// File: rtl/twiddle_seq.sv
// Strided twiddle-factor sequencer: streams LANES table entries per beat,
// optionally conjugated, with valid/ready backpressure and frame looping.

// One output lane: fetch entry (base + K*2^shift) mod N, conjugate if asked.
module twiddle_lane #(
  parameter int NBITS = 16,
  parameter int N     = 8,
  parameter int K     = 0,
  parameter int SW    = $clog2(N)
) (
  input  logic [N*2*NBITS-1:0] tbl_flat,
  input  logic [SW-1:0]        base,
  input  logic [SW-1:0]        shift,
  input  logic                 inverse,
  output logic [2*NBITS-1:0]   coef
);
  localparam logic [NBITS-1:0] MINV = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] MAXV = {1'b0, {(NBITS-1){1'b1}}};

  logic [N-1:0][2*NBITS-1:0] tbl;
  logic [SW-1:0]             addr;
  logic [2*NBITS-1:0]        ent;
  logic [NBITS-1:0]          im;

  assign tbl  = tbl_flat;
  assign addr = base + (SW'(K) << shift);
  // entry 0 lives in the MSBs, so entry i is packed element N-1-i == ~i
  assign ent  = tbl[~addr];
  assign im   = ent[NBITS-1:0];
  // negating the most negative value would wrap, so clamp it to max positive
  assign coef = {ent[2*NBITS-1:NBITS],
                 inverse ? ((im == MINV) ? MAXV : -im) : im};
endmodule

module twiddle_seq #(
  parameter int NBITS = 16,
  parameter int N     = 8,
  parameter int LANES = 2
) (
  input  logic     clk,
  input  logic     rst,
  twiddle_if.slave bus
);
  localparam int W     = 2*NBITS;
  localparam int SW    = $clog2(N);
  localparam int BEATS = N/LANES;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state;
  logic [SW-1:0]              idx, bc, shift_q;
  logic                       inv_q;
  logic                       vld_q, busy_q, done_q;
  logic [LANES-1:0][W-1:0]    coef_q, lane_coef;

  logic                       accept, last;
  logic [SW-1:0]              nidx, nshift, stride;
  logic                       ninv;

  assign accept = vld_q & bus.out_ready;
  assign last   = (bc == SW'(BEATS-1));
  assign stride = SW'(LANES) << shift_q;

  // Select base/shift/inverse of the beat formed at this edge: a fresh
  // frame takes the live inputs, otherwise the latched frame settings.
  always_comb begin
    nidx   = '0;
    nshift = shift_q;
    ninv   = inv_q;
    if (state == IDLE) begin
      nshift = bus.shift;
      ninv   = bus.inverse;
    end else if (!last) begin
      nidx = idx + stride;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    twiddle_lane #(.NBITS(NBITS), .N(N), .K(k), .SW(SW)) u_lane (
      .tbl_flat (bus.coeff_table),
      .base     (nidx),
      .shift    (nshift),
      .inverse  (ninv),
      .coef     (lane_coef[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      bc      <= '0;
      shift_q <= '0;
      inv_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      coef_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state   <= RUN;
          idx     <= '0;
          bc      <= '0;
          shift_q <= bus.shift;
          inv_q   <= bus.inverse;
          vld_q   <= 1'b1;
          busy_q  <= 1'b1;
          coef_q  <= lane_coef;
        end
        RUN: if (accept) begin
          if (!last) begin
            idx    <= nidx;
            bc     <= bc + 1'b1;
            coef_q <= lane_coef;
          end else if (bus.loop) begin
            idx    <= '0;
            bc     <= '0;
            coef_q <= lane_coef;
          end else begin
            // coef_q keeps the final beat after the frame closes
            state  <= IDLE;
            idx    <= '0;
            bc     <= '0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.coeff_out = coef_q;
endmodule

// File: tb/tb_twiddle_seq.sv
// Directed bench for twiddle_seq at NBITS=8, N=8, LANES=2.
// Beat words are {lane1 re,im, lane0 re,im}; entry i = {re=i, im=i+16}.
module tb_twiddle_seq;
  logic clk = 1'b0;
  logic rst;
  int   nchk = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  twiddle_if #(.NBITS(8), .N(8), .LANES(2)) bus ();
  twiddle_seq #(.NBITS(8), .N(8), .LANES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  // {out_valid, busy, done}
  wire [2:0] stat = {bus.out_valid, bus.busy, bus.done};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one edge, then settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int i, input logic [7:0] re, input logic [7:0] im);
    bus.coeff_table[127-i*16 -: 16] = {re, im};
  endtask

  task automatic run_frame(input string name, input logic [2:0] sh, input logic inv,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    bus.start = 1'b1; bus.shift = sh; bus.inverse = inv;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s beat%0d", name, i), 64'(bus.coeff_out), 64'(e[i]));
      chk($sformatf("%s stat%0d", name, i), 64'(stat), 64'(3'b110));
      tick();
    end
    chk({name, " done"}, 64'(stat), 64'(3'b001));
    chk({name, " hold"}, 64'(bus.coeff_out), 64'(e3));
    tick();
    chk({name, " idle"}, 64'(stat), 64'(3'b000));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b1; bus.shift = '0; bus.inverse = 1'b0; bus.loop = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) set_entry(i, 8'(i), 8'(i + 16));

    // reset held with start asserted
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rst stat%0d", c), 64'(stat), 64'(3'b000));
      chk($sformatf("rst coef%0d", c), 64'(bus.coeff_out), 64'h0);
    end
    rst = 1'b0; bus.start = 1'b0;
    tick();
    chk("post-rst idle", 64'(stat), 64'(3'b000));

    // straight frame
    run_frame("seq", 3'd0, 1'b0, 32'h0111_0010, 32'h0313_0212,
              32'h0515_0414, 32'h0717_0616);

    // stride 2 wraps the address
    run_frame("stride", 3'd1, 1'b0, 32'h0212_0010, 32'h0616_0414,
              32'h0212_0010, 32'h0616_0414);

    // stall on beat 1, start held high through the frame is ignored
    bus.start = 1'b1; bus.shift = 3'd0; bus.inverse = 1'b0;
    tick();
    chk("stall beat0", 64'(bus.coeff_out), 64'h0111_0010);
    tick();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall hold%0d", c), 64'(bus.coeff_out), 64'h0313_0212);
      chk($sformatf("stall vld%0d", c), 64'(stat), 64'(3'b110));
    end
    bus.out_ready = 1'b1;
    tick();
    chk("stall beat2", 64'(bus.coeff_out), 64'h0515_0414);
    tick();
    chk("stall beat3", 64'(bus.coeff_out), 64'h0717_0616);
    tick();
    chk("start ignored at end", 64'(stat), 64'(3'b001));
    bus.start = 1'b0;
    tick();
    chk("stall idle", 64'(stat), 64'(3'b000));

    // conjugate, with saturation of im = -128 on entry 3
    set_entry(3, 8'd3, 8'h80);
    bus.start = 1'b1; bus.inverse = 1'b1;
    tick();
    bus.start = 1'b0; bus.inverse = 1'b0;
    chk("inv beat0", 64'(bus.coeff_out), 64'h01EF_00F0);
    tick();
    chk("inv beat1 sat", 64'(bus.coeff_out), 64'h037F_02EE);
    tick();
    chk("inv beat2", 64'(bus.coeff_out), 64'h05EB_04EC);
    tick(); tick();
    chk("inv done", 64'(stat), 64'(3'b001));
    set_entry(3, 8'd3, 8'd19);
    tick();

    // looping: frame 2 restarts at beat 0, no done pulse, then reset mid-stall
    bus.loop = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("loop nodone%0d", i), 64'(stat), 64'(3'b110));
      tick();
    end
    chk("loop beat5", 64'(bus.coeff_out), 64'h0313_0212);
    bus.out_ready = 1'b0;
    tick();
    chk("loop stall", 64'(bus.coeff_out), 64'h0313_0212);
    rst = 1'b1;
    tick();
    chk("midrst stat", 64'(stat), 64'(3'b000));
    chk("midrst coef", 64'(bus.coeff_out), 64'h0);
    rst = 1'b0; bus.out_ready = 1'b1;
    tick();
    chk("midrst idle", 64'(stat), 64'(3'b000));

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
